// File: rtl/instruction_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cycle_controller
// Description : Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cycle_controller #(
   parameter int ENTER_EDGE = 1
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [2:0] IR75,
   input  logic       Aeq0,
   input  logic       Apos,
   input  logic       enter,
   output logic       IRload,
   output logic       PCload,
   output logic       IMPsel,
   output logic       MeminstSel,
   output logic       MemWr,
   output logic       Aload,
   output logic [1:0] Asel,
   output logic       Sub,
   output logic       Halt,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      ST_START  = 3'b000,
      ST_FETCH  = 3'b001,
      ST_DECODE = 3'b010,
      ST_EXEC   = 3'b011,
      ST_WAITIN = 3'b100,
      ST_HALT   = 3'b101
   } state_t;

   localparam logic [2:0] c_OP_HALT  = 3'b000;
   localparam logic [2:0] c_OP_LOAD  = 3'b001;
   localparam logic [2:0] c_OP_STORE = 3'b010;
   localparam logic [2:0] c_OP_ADD   = 3'b011;
   localparam logic [2:0] c_OP_SUB   = 3'b100;
   localparam logic [2:0] c_OP_INPUT = 3'b101;
   localparam logic [2:0] c_OP_JZ    = 3'b110;
   localparam logic [2:0] c_OP_JPOS  = 3'b111;

   localparam logic [1:0] c_ASEL_ALU = 2'b00;
   localparam logic [1:0] c_ASEL_IN  = 2'b01;
   localparam logic [1:0] c_ASEL_MEM = 2'b10;

   state_t r_state;
   state_t w_next;
   logic   r_enter_q;
   logic   w_enter_done;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state   <= ST_START;
         r_enter_q <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_enter_q <= enter;
      end
   end

   // Edge mode needs enter released and re-pressed, even if already high on entry.
   generate
      if (ENTER_EDGE != 0) begin : g_enter_edge
         assign w_enter_done = enter & ~r_enter_q;
      end else begin : g_enter_level
         assign w_enter_done = enter;
      end
   endgenerate

   always_comb begin
      w_next     = ST_START;
      IRload     = 1'b0;
      PCload     = 1'b0;
      IMPsel     = 1'b0;
      MeminstSel = 1'b0;
      MemWr      = 1'b0;
      Aload      = 1'b0;
      Asel       = c_ASEL_ALU;
      Sub        = 1'b0;
      Halt       = 1'b0;

      case (r_state)
         ST_START: begin
            w_next = ST_FETCH;
         end

         ST_FETCH: begin
            IRload = 1'b1;
            PCload = 1'b1;
            w_next = ST_DECODE;
         end

         ST_DECODE: begin
            MeminstSel = 1'b1;
            w_next     = (IR75 == c_OP_HALT) ? ST_HALT : ST_EXEC;
         end

         ST_EXEC: begin
            MeminstSel = 1'b1;
            w_next     = ST_FETCH;
            case (IR75)
               c_OP_LOAD: begin
                  Asel  = c_ASEL_MEM;
                  Aload = 1'b1;
               end
               c_OP_STORE: begin
                  MemWr = 1'b1;
               end
               c_OP_ADD: begin
                  Aload = 1'b1;
               end
               c_OP_SUB: begin
                  Sub   = 1'b1;
                  Aload = 1'b1;
               end
               c_OP_INPUT: begin
                  w_next = ST_WAITIN;
               end
               c_OP_JZ: begin
                  IMPsel = Aeq0;
                  PCload = Aeq0;
               end
               c_OP_JPOS: begin
                  IMPsel = Apos;
                  PCload = Apos;
               end
               default: begin
                  w_next = ST_FETCH;
               end
            endcase
         end

         ST_WAITIN: begin
            Asel   = c_ASEL_IN;
            Aload  = w_enter_done;
            w_next = w_enter_done ? ST_FETCH : ST_WAITIN;
         end

         ST_HALT: begin
            Halt   = 1'b1;
            w_next = ST_HALT;
         end

         default: begin
            w_next = ST_START;
         end
      endcase
   end

   assign State = r_state;

endmodule
`default_nettype wire

// File: doc/instruction_cycle_controller.md
Name: instruction_cycle_controller

Overview:
Moore/Mealy FSM that sequences the 8-bit instruction-cycle datapath (IR, PC, PC-increment mux, instruction-memory address mux, accumulator, memory).
It drives the fetch, decode and execute control strobes from the 3-bit opcode IR[7:5] and the accumulator status flags.
INPUT uses a handshake on `enter`; HALT parks the processor until reset.

Parameters:
ENTER_EDGE, 1, 1 = INPUT completes on a rising edge of `enter`; 0 = INPUT completes on level `enter`=1.

Ports:
clk  input  1  system clock, rising-edge.
clear  input  1  asynchronous, active-low reset.
IR75  input  3  opcode, IR[7:5].
Aeq0  input  1  accumulator == 0.
Apos  input  1  accumulator > 0 (signed, nonzero, MSB=0).
enter  input  1  user-input strobe for INPUT.
IRload  output  1  load IR from memory data.
PCload  output  1  load PC from IMP mux.
IMPsel  output  1  0 = PC+1, 1 = IR[4:0].
MeminstSel  output  1  memory address: 0 = PC, 1 = IR[4:0].
MemWr  output  1  write accumulator to memory at address IR[4:0].
Aload  output  1  load accumulator.
Asel  output  2  accumulator source: 00 = adder/subtractor, 01 = input port, 10 = memory data, 11 = unused.
Sub  output  1  0 = add, 1 = subtract.
Halt  output  1  processor halted.
State  output  3  current state, for debug.

Behaviour:
- States and encodings: START=000, FETCH=001, DECODE=010, EXEC=011, WAITIN=100, HALT=101. Codes 110 and 111 are illegal and go to START.
- Reset: clear=0 asynchronously forces START and clears the enter-edge register. All outputs are 0 and State=000 while clear=0.
- Reset mid-instruction aborts the instruction; no strobe may be asserted during reset.
- START: all strobes 0. Next state is FETCH unconditionally.
- FETCH: MeminstSel=0, IRload=1, PCload=1, IMPsel=0. This loads IR=mem[PC] and PC=PC+1. Next state is DECODE.
- DECODE: MeminstSel=1 (operand address presented), all other strobes 0. Next state is EXEC, or HALT if IR75=000.
- EXEC (MeminstSel=1 throughout), by opcode:
  - 001 LOAD: Asel=10, Aload=1.
  - 010 STORE: MemWr=1.
  - 011 ADD: Asel=00, Sub=0, Aload=1.
  - 100 SUB: Asel=00, Sub=1, Aload=1.
  - 101 INPUT: no strobes; next state is WAITIN.
  - 110 JZ: if Aeq0, IMPsel=1 and PCload=1 (Mealy on the flag).
  - 111 JPOS: if Apos, IMPsel=1 and PCload=1.
  - Next state is FETCH for all opcodes except INPUT.
- WAITIN: Asel=01 whenever in this state.
  - ENTER_EDGE=1: completion when enter=1 and the registered enter from the previous cycle was 0. The enter register samples every cycle in all states, so an enter already high on entry requires a release first.
  - ENTER_EDGE=0: completion when enter=1.
  - On completion: Aload=1 in that cycle, next state FETCH. Otherwise remain in WAITIN with Aload=0.
- HALT: Halt=1, all other strobes 0. Stays in HALT until clear=0. `enter` is ignored.
- Latency:
  - Non-INPUT instructions take exactly 3 cycles (FETCH, DECODE, EXEC).
  - INPUT takes 3 cycles + 1 per cycle waited in WAITIN.
  - HALT reaches the HALT state 2 cycles after FETCH.
- Mutual exclusion: Aload and MemWr are never both 1. PCload=1 with IMPsel=1 occurs only in EXEC for a taken jump.
- Outputs are combinational from the state register, IR75, Aeq0, Apos, enter and the enter register. The state register is the only state besides the enter register.

Test Plan:
- Reset and fetch: hold clear=0 for 2 cycles, then release.
  -> All outputs 0 and State=000 during reset.
  -> After release: START, then FETCH with IRload=PCload=1, IMPsel=MeminstSel=0, then DECODE with MeminstSel=1.
- ADD (IR75=011) and SUB (IR75=100):
  -> EXEC shows Aload=1, Asel=00, Sub=0 / Sub=1, MeminstSel=1.
  -> Next cycle is FETCH; 3 cycles per instruction.
- JZ (IR75=110) with Aeq0=1 then Aeq0=0:
  -> Taken: EXEC shows PCload=1, IMPsel=1.
  -> Not taken: EXEC shows PCload=0.
  -> Repeat for JPOS (IR75=111) with Apos=1/0.
- INPUT (IR75=101), ENTER_EDGE=1, enter held 1 on entry to WAITIN for 3 cycles, then 0 for 2 cycles, then 1:
  -> WAITIN holds with Aload=0 until the rising edge.
  -> Aload=1, Asel=01 in the edge cycle, then FETCH.
  -> With ENTER_EDGE=0: completes in the first WAITIN cycle.
- STORE then HALT (IR75=010, then 000):
  -> EXEC shows MemWr=1, Aload=0.
  -> HALT instruction: DECODE goes to HALT, Halt=1 held for 10 cycles regardless of enter.
- Async reset mid-EXEC and mid-WAITIN (clear pulled low between clock edges):
  -> State=000 and all strobes 0 immediately, without waiting for a clock edge.
  -> Normal restart from START after release.
